// File: rtl/sine_pkg.sv
// Shared quadrant types and elaboration-time helpers for the quarter-wave sine/cosine lookup.
// The table generator runs only at elaboration; nothing here becomes runtime arithmetic.
package sine_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // Peak amplitude of the stored quarter wave (Q12 scaling).
  localparam int  SINE_AMP = 4095;
  localparam real PI_HALF  = 1.5707963267948966;

  // Odd quadrants read the quarter table mirrored; inverting idx gives N-1-idx.
  // Callers use at most 16 address bits and size-cast the result down to their own width.
  function automatic logic [15:0] fold_addr(input logic [15:0] idx, input quad_t q);
    return (q == Q1 || q == Q3) ? ~idx : idx;
  endfunction

  function automatic logic neg_flag(input quad_t q);
    return (q == Q2 || q == Q3);
  endfunction

  // Taylor series in Horner form, accurate far below one LSB on [0, pi/2].
  function automatic real sin_poly(input real x);
    real x2;
    x2 = x * x;
    return x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 *
           (1.0 - x2 / 72.0 * (1.0 - x2 / 110.0 * (1.0 - x2 / 156.0 *
           (1.0 - x2 / 210.0 * (1.0 - x2 / 272.0))))))));
  endfunction

  // Entry k of an n-entry quarter table, sampled at the half-step so the mirror is exact.
  function automatic int qtr_entry(input int k, input int n, input int amp);
    real x;
    x = PI_HALF * (real'(k) + 0.5) / real'(n);
    return $rtoi(real'(amp) * sin_poly(x) + 0.5);
  endfunction

endpackage

// File: rtl/sincos_lut_pipe_if.sv
// Phase-in / sample-out valid-ready stream bundle for the sine/cosine lookup pipeline.
interface sincos_lut_pipe_if #(
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int TAG_WIDTH   = 2
);

  logic                         in_valid;
  logic                         in_ready;
  logic [PHASE_WIDTH-1:0]       in_phase;
  logic [TAG_WIDTH-1:0]         in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_sin;
  logic signed [DATA_WIDTH-1:0] out_cos;
  logic [TAG_WIDTH-1:0]         out_tag;

  // Master produces phase words and consumes samples.
  modport master (
    output in_valid, in_phase, in_tag, out_ready,
    input  in_ready, out_valid, out_sin, out_cos, out_tag
  );

  modport slave (
    input  in_valid, in_phase, in_tag, out_ready,
    output in_ready, out_valid, out_sin, out_cos, out_tag
  );

endinterface

// File: rtl/sine_qtr_rom.sv
// Dual-read-port synchronous quarter-wave ROM; contents fixed at elaboration.
// Each port holds its last read while its enable is low, which is how the pipeline stalls.
module sine_qtr_rom
  import sine_pkg::*;
#(
  parameter int    ADDR_WIDTH = 8,
  parameter int    DATA_WIDTH = 16,
  parameter string MEM_FILE   = "sim/sine_qtr_q12.mem"
) (
  input  logic                         clk,
  input  logic                         rd_en_a,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_a,
  output logic signed [DATA_WIDTH-1:0] rd_data_a,
  input  logic                         rd_en_b,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_b,
  output logic signed [DATA_WIDTH-1:0] rd_data_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic signed [DATA_WIDTH-1:0] qtr_tbl [DEPTH];
  logic signed [DATA_WIDTH-1:0] rd_data_a_d, rd_data_a_q;
  logic signed [DATA_WIDTH-1:0] rd_data_b_d, rd_data_b_q;

  // The table is computed here from the same formula that produces the MEM_FILE image,
  // so no file has to travel with the netlist; an empty name only marks that intent.
  if (MEM_FILE == "") begin : g_no_image_name
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    assign qtr_tbl[k] = DATA_WIDTH'(qtr_entry(k, DEPTH, SINE_AMP));
  end

  always_comb begin
    rd_data_a_d = rd_en_a ? qtr_tbl[rd_addr_a] : rd_data_a_q;
    rd_data_b_d = rd_en_b ? qtr_tbl[rd_addr_b] : rd_data_b_q;
  end

  // NOTE: ROM read registers carry no reset so the read maps onto block-RAM output registers;
  // valid bits in the pipeline decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    rd_data_a_q <= rd_data_a_d;
    rd_data_b_q <= rd_data_b_d;
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

endmodule

// File: rtl/sincos_lut_pipe.sv
// Three-stage quarter-wave sin/cos lookup: fold phase to table address, read, restore sign.
// A single advance signal moves every stage, so a downstream stall freezes the whole pipe.
module sincos_lut_pipe
  import sine_pkg::*;
#(
  parameter int    PHASE_WIDTH = 10,
  parameter int    ADDR_WIDTH  = 8,
  parameter int    DATA_WIDTH  = 16,
  parameter int    TAG_WIDTH   = 2,
  parameter string MEM_FILE    = "sim/sine_qtr_q12.mem"
) (
  input logic              clk,
  input logic              rst_n,
  sincos_lut_pipe_if.slave bus
);

  logic                         advance;
  quad_t                        sin_quad;
  quad_t                        cos_quad;
  logic [ADDR_WIDTH-1:0]        phase_idx;

  logic                         s1_valid_d, s1_valid_q;
  logic [ADDR_WIDTH-1:0]        s1_sin_addr_d, s1_sin_addr_q;
  logic [ADDR_WIDTH-1:0]        s1_cos_addr_d, s1_cos_addr_q;
  logic                         s1_sin_neg_d, s1_sin_neg_q;
  logic                         s1_cos_neg_d, s1_cos_neg_q;
  logic [TAG_WIDTH-1:0]         s1_tag_d, s1_tag_q;

  logic                         s2_valid_d, s2_valid_q;
  logic                         s2_sin_neg_d, s2_sin_neg_q;
  logic                         s2_cos_neg_d, s2_cos_neg_q;
  logic [TAG_WIDTH-1:0]         s2_tag_d, s2_tag_q;
  logic signed [DATA_WIDTH-1:0] rom_sin, rom_cos;

  logic                         out_valid_d, out_valid_q;
  logic signed [DATA_WIDTH-1:0] out_sin_d, out_sin_q;
  logic signed [DATA_WIDTH-1:0] out_cos_d, out_cos_q;
  logic [TAG_WIDTH-1:0]         out_tag_d, out_tag_q;

  // Cosine is sine one quadrant ahead; the wrap from Q3 to Q0 falls out of 2-bit arithmetic.
  always_comb begin
    advance   = !out_valid_q || bus.out_ready;
    sin_quad  = quad_t'(bus.in_phase[PHASE_WIDTH-1 -: 2]);
    cos_quad  = quad_t'(2'(sin_quad) + 2'd1);
    phase_idx = bus.in_phase[PHASE_WIDTH-3 -: ADDR_WIDTH];
  end

  // NOTE: every _d starts from its _q so a stall is an explicit hold and no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sin_addr_d = s1_sin_addr_q;
    s1_cos_addr_d = s1_cos_addr_q;
    s1_sin_neg_d  = s1_sin_neg_q;
    s1_cos_neg_d  = s1_cos_neg_q;
    s1_tag_d      = s1_tag_q;
    s2_valid_d    = s2_valid_q;
    s2_sin_neg_d  = s2_sin_neg_q;
    s2_cos_neg_d  = s2_cos_neg_q;
    s2_tag_d      = s2_tag_q;
    out_valid_d   = out_valid_q;
    out_sin_d     = out_sin_q;
    out_cos_d     = out_cos_q;
    out_tag_d     = out_tag_q;
    if (advance) begin
      s1_valid_d    = bus.in_valid;
      s1_sin_addr_d = ADDR_WIDTH'(fold_addr(16'(phase_idx), sin_quad));
      s1_cos_addr_d = ADDR_WIDTH'(fold_addr(16'(phase_idx), cos_quad));
      s1_sin_neg_d  = neg_flag(sin_quad);
      s1_cos_neg_d  = neg_flag(cos_quad);
      s1_tag_d      = bus.in_tag;
      s2_valid_d    = s1_valid_q;
      s2_sin_neg_d  = s1_sin_neg_q;
      s2_cos_neg_d  = s1_cos_neg_q;
      s2_tag_d      = s1_tag_q;
      out_valid_d   = s2_valid_q;
      out_sin_d     = s2_sin_neg_q ? -rom_sin : rom_sin;
      out_cos_d     = s2_cos_neg_q ? -rom_cos : rom_cos;
      out_tag_d     = s2_tag_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // pre-edge value of the stage before it, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sin_addr_q <= '0;
      s1_cos_addr_q <= '0;
      s1_sin_neg_q  <= 1'b0;
      s1_cos_neg_q  <= 1'b0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sin_neg_q  <= 1'b0;
      s2_cos_neg_q  <= 1'b0;
      s2_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_sin_q     <= '0;
      out_cos_q     <= '0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sin_addr_q <= s1_sin_addr_d;
      s1_cos_addr_q <= s1_cos_addr_d;
      s1_sin_neg_q  <= s1_sin_neg_d;
      s1_cos_neg_q  <= s1_cos_neg_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_sin_neg_q  <= s2_sin_neg_d;
      s2_cos_neg_q  <= s2_cos_neg_d;
      s2_tag_q      <= s2_tag_d;
      out_valid_q   <= out_valid_d;
      out_sin_q     <= out_sin_d;
      out_cos_q     <= out_cos_d;
      out_tag_q     <= out_tag_d;
    end
  end

  // The ROM read registers form stage 2's data half.
  sine_qtr_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_FILE   (MEM_FILE)
  ) u_rom (
    .clk       (clk),
    .rd_en_a   (advance),
    .rd_addr_a (s1_sin_addr_q),
    .rd_data_a (rom_sin),
    .rd_en_b   (advance),
    .rd_addr_b (s1_cos_addr_q),
    .rd_data_b (rom_cos)
  );

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sin   = out_sin_q;
  assign bus.out_cos   = out_cos_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_sincos_lut_pipe.sv
// Self-checking bench for sincos_lut_pipe: directed table, full sweep, stall, random traffic, reset.
// A negedge monitor pushes expectations on input handshakes and compares them on output handshakes.
module tb_sincos_lut_pipe;

  localparam int PW  = 10;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TW  = 2;
  localparam int AMP = 4095;
  localparam real TWO_PI = 6.283185307179586;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sincos_lut_pipe_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  sincos_lut_pipe #(
    .PHASE_WIDTH (PW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [TW-1:0] tag;
    int            s;
    int            c;
  } exp_t;

  typedef struct {
    int phase;
    int s;
    int c;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   out_count = 0;
  bit   in_fire_last = 1'b0;
  bit   capture = 1'b0;
  int   cap_n = 0;
  int   cap_first = 0;
  int   cap_last = 0;
  int   cap_s [1024];
  int   cap_c [1024];
  bit   rand_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int round_away(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Reference: sample the ideal wave at the centre of each table step.
  function automatic int model_sin(input int p);
    return round_away(real'(AMP) * $sin(TWO_PI * (real'(p) + 0.5) / 1024.0));
  endfunction

  function automatic int model_cos(input int p);
    return round_away(real'(AMP) * $cos(TWO_PI * (real'(p) + 0.5) / 1024.0));
  endfunction

  // Monitor: stable values between edges describe the handshake at the next rising edge.
  always @(negedge clk) begin : monitor
    cyc++;
    in_fire_last = 1'b0;
    if (rst_n) begin
      in_fire_last = bus.in_valid && bus.in_ready;
      if (in_fire_last) sb.push_back(cur_exp);
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        check("sb_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("sb_sin", int'(bus.out_sin), mon_e.s);
          check("sb_cos", int'(bus.out_cos), mon_e.c);
          check("sb_tag", int'(bus.out_tag), int'(mon_e.tag));
        end
        if (capture && cap_n < 1024) begin
          if (cap_n == 0) cap_first = cyc;
          cap_last       = cyc;
          cap_s[cap_n]   = int'(bus.out_sin);
          cap_c[cap_n]   = int'(bus.out_cos);
          cap_n++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the word was taken.
  task automatic send(input int phase, input int tag, input int es, input int ec);
    bus.in_phase = PW'(phase);
    bus.in_tag   = TW'(tag);
    bus.in_valid = 1'b1;
    cur_exp      = '{tag: TW'(tag), s: es, c: ec};
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (in_fire_last) return;
    end
    check("send_timeout", int'(in_fire_last), 1);
  endtask

  task automatic send_model(input int phase, input int tag);
    send(phase, tag, model_sin(phase), model_cos(phase));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 500 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Sends one word into an empty pipe and counts edges until out_valid, accept edge included.
  task automatic latency_probe(input int phase, input int tag, input int es, input int ec);
    int lat;
    send(phase, tag, es, ec);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    vec_t vecs [8];
    int   base;
    int   held_s, held_c, held_t;
    int   pw;

    vecs[0] = '{phase: 0,    s: 13,    c: 4095};
    vecs[1] = '{phase: 256,  s: 4095,  c: -13};
    vecs[2] = '{phase: 512,  s: -13,   c: -4095};
    vecs[3] = '{phase: 768,  s: -4095, c: 13};
    vecs[4] = '{phase: 255,  s: 4095,  c: 13};
    vecs[5] = '{phase: 511,  s: 13,    c: -4095};
    vecs[6] = '{phase: 767,  s: -4095, c: -13};
    vecs[7] = '{phase: 1023, s: -13,   c: 4095};

    bus.in_valid  = 1'b0;
    bus.in_phase  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    cur_exp       = '{tag: '0, s: 0, c: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sin", int'(bus.out_sin), 0);
    check("rst_out_cos", int'(bus.out_cos), 0);
    check("rst_out_tag", int'(bus.out_tag), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    idle(2);

    // 1: phase 0 through an empty pipe
    latency_probe(0, 1, 13, 4095);
    drain();

    // 2: quadrant boundaries back to back from the table
    for (int i = 0; i < 8; i++) send(vecs[i].phase, i % 4, vecs[i].s, vecs[i].c);
    drain();

    // 3: full sweep at one word per cycle
    capture = 1'b1;
    cap_n   = 0;
    for (int p = 0; p < 1024; p++) send_model(p, p % 4);
    drain();
    capture = 1'b0;
    check("sweep_count", cap_n, 1024);
    check("sweep_consecutive", cap_last - cap_first, 1023);
    for (int p = 0; p < 512; p++) check("sweep_half_wave", cap_s[p], -cap_s[p + 512]);
    for (int p = 0; p < 1024; p++) begin
      int e;
      e = cap_s[p] * cap_s[p] + cap_c[p] * cap_c[p] - AMP * AMP;
      check("sweep_energy", int'((e < 0 ? -e : e) <= 2 * AMP), 1);
    end

    // 4: downstream stall mid-stream
    base = out_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(i * 100 + 7, i % 4);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        held_s = int'(bus.out_sin);
        held_c = int'(bus.out_cos);
        held_t = int'(bus.out_tag);
        repeat (5) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", int'(bus.in_ready), 0);
          check("stall_out_valid", int'(bus.out_valid), 1);
          check("stall_sin_stable", int'(bus.out_sin), held_s);
          check("stall_cos_stable", int'(bus.out_cos), held_c);
          check("stall_tag_stable", int'(bus.out_tag), held_t);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered", out_count - base, 8);

    // 5: random valid/ready traffic
    base      = out_count;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 1) == 0) idle(1);
          send_model(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
        end
        bus.in_valid = 1'b0;
        rand_done    = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("random_delivered", out_count - base, 10000);

    // 6: asynchronous reset with three words in flight
    send_model(100, 1);
    send_model(200, 2);
    send_model(300, 3);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    sb.delete();
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_sin", int'(bus.out_sin), 0);
    check("arst_out_cos", int'(bus.out_cos), 0);
    check("arst_out_tag", int'(bus.out_tag), 0);
    check("arst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pw    = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) pw++;
    end
    check("arst_no_stale", pw, 0);
    @(posedge clk);
    #1;
    latency_probe(0, 2, 13, 4095);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
